// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_scheduler
// Brief   : Round-robin arbiter that shares one UART transmitter among
//           NUM_REQ byte requesters and paces sends to one frame plus gap.
// Revision: 1.0 - initial release
// ============================================================================

module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BITS   = 10,
    parameter int GAP_CLKS     = 0,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic                 tx_send_o,
    output logic [7:0]           tx_data_o,
    output logic                 busy_o,
    output logic [ID_W-1:0]      grant_id_o
);

    localparam int C_FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
    localparam int C_TOTAL_CLKS = C_FRAME_CLKS + GAP_CLKS;
    localparam int CNT_W        = $clog2(C_TOTAL_CLKS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [7:0]        data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W:0]     cand_sum;
    logic [ID_W-1:0]   cand_id;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        req_found = 1'b0;
        pick_id   = '0;
        cand_sum  = '0;
        cand_id   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (cand_sum >= (ID_W + 1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_W + 1)'(NUM_REQ);
            end
            cand_id = cand_sum[ID_W-1:0];
            if (req_i[cand_id]) begin
                req_found = 1'b1;
                pick_id   = cand_id;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        tx_send_o = 1'b0;
        ack_o     = '0;
        busy_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    grant_d = pick_id;
                    data_d  = req_data_i[8*pick_id +: 8];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_send_o = 1'b1;
                ack_o     = NUM_REQ'(1) << grant_q;
                busy_o    = 1'b1;
                cnt_d     = CNT_W'(C_TOTAL_CLKS - 1);
                ptr_d     = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                busy_o = 1'b1;
                // Leaving on the step to zero keeps busy at exactly one frame+gap including SEND.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_data_o  = data_q;
    assign grant_id_o = grant_q;

endmodule

`default_nettype wire
